tc21073_div_8: RTL and testbench

Sequential 8-bit unsigned restoring divider. Each cycle it makes one trial subtraction through the team's 8-bit ripple subtractor stage (a + ~b + cin; cout = 1 means no borrow) and uses the sum and cout to build the quotient one bit per cycle. Arithmetic-lab datapath; accepts operands under a start/busy/done handshake.

---
 rtl/tc21073_div_pkg.sv | 6 +
 rtl/tc21073_div_8_if.sv | 20 ++
 rtl/tc21073_div_8_sub.sv | 20 ++
 rtl/tc21073_div_8.sv | 89 ++++++++
 tb/tb_tc21073_div_8.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/tc21073_div_pkg.sv
// tc21073_div_pkg: shared width constants and FSM state type for the 8-bit restoring divider.
package tc21073_div_pkg;
    localparam int DW = 8;
    localparam int ITER_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
endpackage

// File: rtl/tc21073_div_8_if.sv
// tc21073_div_8_if: start/busy/done handshake plus operand and result buses of the divider.
interface tc21073_div_8_if;
    import tc21073_div_pkg::*;
    logic start;
    logic [DW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic busy;
    logic done;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic div_by_zero;
    modport master (
        output start, dividend, divisor,
        input busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/tc21073_div_8_sub.sv
// tc21073_div_8_sub: 8-bit ripple subtractor stage, sum = a + ~b + cin; cout = 1 means no borrow.
module tc21073_div_8_sub
    import tc21073_div_pkg::*;
(
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic          cin_i,
    output logic [DW-1:0] sum_o,
    output logic          cout_o
);
    logic [DW-1:0] nb;
    logic [DW:0] c;
    assign nb = ~b_i;
    assign c[0] = cin_i;
    for (genvar g = 0; g < DW; g++) begin : g_fa
        assign sum_o[g] = a_i[g] ^ nb[g] ^ c[g];
        assign c[g+1] = (a_i[g] & nb[g]) | (c[g] & (a_i[g] ^ nb[g]));
    end
    assign cout_o = c[DW];
endmodule

// File: rtl/tc21073_div_8.sv
// tc21073_div_8: sequential 8-bit unsigned restoring divider, one quotient bit per cycle.
// Define TC21073_DIV_DBZ_EN to finish a zero-divisor request immediately and flag div_by_zero.
module tc21073_div_8
    import tc21073_div_pkg::*;
(
    input logic clk,
    input logic rst,
    tc21073_div_8_if.slave bus
);
    div_state_t state_q, state_d;
    logic [DW-1:0] q_q, r_q, d_q, quot_q, rem_q;
    logic [DW-1:0] sum, r_nxt, q_nxt;
    logic [ITER_W-1:0] cnt_q;
    logic [DW:0] r9;
    logic cout, accept, go, last, dbz_start;

    assign go = bus.start && state_q != RUN;
    assign last = cnt_q == ITER_W'(DW - 1);
    assign r9 = {r_q, q_q[DW-1]};

    tc21073_div_8_sub u_sub (
        .a_i    (r9[DW-1:0]),
        .b_i    (d_q),
        .cin_i  (1'b1),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // a set ninth bit means the shifted remainder already exceeds any 8-bit divisor
    assign accept = r9[DW] | cout;
    assign r_nxt = accept ? sum : r9[DW-1:0];
    assign q_nxt = {q_q[DW-2:0], accept};

`ifdef TC21073_DIV_DBZ_EN
    logic dbz_q;
    assign dbz_start = bus.divisor == '0;
    assign bus.div_by_zero = dbz_q;
    always_ff @(posedge clk) begin
        if (rst) dbz_q <= 1'b0;
        else if (go) dbz_q <= dbz_start;
    end
`else
    assign dbz_start = 1'b0;
    assign bus.div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == RUN ? (last ? DONE : RUN) : go ? (dbz_start ? DONE : RUN) : IDLE;
    end

    always_comb begin
        bus.busy = state_q == RUN;
        bus.done = state_q == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
            r_q <= '0;
            d_q <= '0;
            cnt_q <= '0;
            quot_q <= '0;
            rem_q <= '0;
        end else if (go) begin
            q_q <= bus.dividend;
            r_q <= '0;
            d_q <= bus.divisor;
            cnt_q <= '0;
            quot_q <= dbz_start ? '1 : '0;
            rem_q <= dbz_start ? bus.dividend : '0;
        end else if (state_q == RUN) begin
            q_q <= q_nxt;
            r_q <= r_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                quot_q <= q_nxt;
                rem_q <= r_nxt;
            end
        end
    end

    assign bus.quotient = quot_q;
    assign bus.remainder = rem_q;
endmodule

// File: tb/tb_tc21073_div_8.sv
// tb_tc21073_div_8: directed scoreboard bench for the restoring divider.
module tb_tc21073_div_8;
    import tc21073_div_pkg::*;

`ifdef TC21073_DIV_DBZ_EN
    localparam bit DBZ = 1'b1;
`else
    localparam bit DBZ = 1'b0;
`endif

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic z;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic done_prev = 1'b0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tc21073_div_8_if bus();
    tc21073_div_8 dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic go(input logic [7:0] a, input logic [7:0] b, input bit push);
        exp_t x;
        bus.dividend = a;
        bus.divisor = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (push) begin
            x.q = (b == 0) ? 8'hFF : a / b;
            x.r = (b == 0) ? a : a % b;
            x.z = (b == 0) && DBZ;
            x.cyc = cyc + (((b == 0) && DBZ) ? 0 : 8);
            sb.push_back(x);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", {31'b0, bus.done}, 1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy_done_excl", {31'b0, bus.busy & bus.done}, 0);
            if (bus.done) begin
                chk("done_single", {31'b0, done_prev}, 0);
                chk("unexpected_done", {31'b0, sb.size() == 0}, 0);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("quotient", {24'b0, bus.quotient}, {24'b0, e.q});
                    chk("remainder", {24'b0, bus.remainder}, {24'b0, e.r});
                    chk("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, e.z});
                    chk("latency", cyc, e.cyc);
                end
            end
        end
        done_prev = bus.done;
    end

    initial begin
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_done", {31'b0, bus.done}, 0);
        chk("rst_quot", {24'b0, bus.quotient}, 0);
        chk("rst_rem", {24'b0, bus.remainder}, 0);
        chk("rst_dbz", {31'b0, bus.div_by_zero}, 0);
        rst = 1'b0;
        @(negedge clk);

        go(100, 7, 1);
        chk("busy_after_start", {31'b0, bus.busy}, 1);
        wait_done();
        repeat (2) @(negedge clk);

        go(255, 1, 1);
        wait_done();
        @(negedge clk);
        go(5, 9, 1);
        wait_done();
        repeat (2) @(negedge clk);

        go(200, 0, 1);
        chk("dbz_busy", {31'b0, bus.busy}, {31'b0, !DBZ});
        wait_done();
        repeat (2) @(negedge clk);

        go(60, 4, 1);
        repeat (2) @(posedge clk);
        #1;
        bus.dividend = 9;
        bus.divisor = 3;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done();
        repeat (2) @(negedge clk);

        go(128, 16, 1);
        wait_done();
        go(17, 5, 1);
        chk("b2b_busy", {31'b0, bus.busy}, 1);
        chk("b2b_done", {31'b0, bus.done}, 0);
        chk("b2b_quot_clr", {24'b0, bus.quotient}, 0);
        wait_done();
        repeat (2) @(negedge clk);

        go(100, 7, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", {31'b0, bus.busy}, 0);
        chk("mid_rst_done", {31'b0, bus.done}, 0);
        chk("mid_rst_quot", {24'b0, bus.quotient}, 0);
        chk("mid_rst_rem", {24'b0, bus.remainder}, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        go(77, 10, 1);
        wait_done();
        repeat (2) @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
